// File: rtl/cache_axi_pkg.sv
// Shared constants and types for the cache-side AXI4 read path.
package cache_axi_pkg;

  localparam int          LINE_BEATS   = 8;
  localparam int          CNT_W        = $clog2(LINE_BEATS);
  localparam logic [7:0]  ARLEN_LINE   = 8'd7;
  localparam logic [7:0]  ARLEN_WORD   = 8'd0;
  localparam logic [2:0]  ARSIZE_WORD  = 3'd2;
  localparam logic [1:0]  ARBURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_DONE
  } rd_state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } rd_owner_e;

  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return {addr[31:5], 5'b0};
  endfunction

endpackage

// File: rtl/cache_rd_beat_buffer.sv
// 8x32 read-beat collector with a saturating write pointer; extra beats
// after the eighth keep overwriting the last word.
module cache_rd_beat_buffer
  import cache_axi_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      wr_en,
  input  logic [31:0]               wdata,
  output logic [LINE_BEATS*32-1:0]  line,
  output logic [CNT_W-1:0]          cnt
);

  logic [LINE_BEATS-1:0][31:0] words;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words <= '0;
      cnt   <= '0;
    end else if (clear) begin
      words <= '0;
      cnt   <= '0;
    end else if (wr_en) begin
      words[cnt] <= wdata;
      if (cnt != CNT_W'(LINE_BEATS - 1))
        cnt <= cnt + 1'b1;
    end
  end

  assign line = words;

endmodule

// File: rtl/cache_rd_arbiter.sv
// Shares one AXI4 read channel between icache and dcache, one transaction at a time.
// Define CACHE_ARB_ROUND_ROBIN_EN for round-robin grants; default is dcache-first.
module cache_rd_arbiter
  import cache_axi_pkg::*;
#(
  parameter logic [3:0] ICACHE_ID = 4'd0,
  parameter logic [3:0] DCACHE_ID = 4'd1
) (
  input  logic         clk,
  input  logic         reset,

  input  logic         i_rd_req,
  input  logic         i_rd_type,
  input  logic [31:0]  i_rd_addr,
  output logic         i_rd_rdy,
  output logic         i_ret_valid,
  output logic [255:0] i_ret_data,

  input  logic         d_rd_req,
  input  logic         d_rd_type,
  input  logic [31:0]  d_rd_addr,
  output logic         d_rd_rdy,
  output logic         d_ret_valid,
  output logic [255:0] d_ret_data,

  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,

  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  rd_state_e  state_q, state_d;
  rd_owner_e  owner_q;
  logic       type_q;
  logic [31:0] addr_q;
  logic       take_grant;
  logic       grant_d;
  logic [255:0] line;
  logic [255:0] ret_word;
  logic [CNT_W-1:0] beat_cnt;
  logic       unused_axi;

  assign unused_axi = ^{rid, rresp, beat_cnt};

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  rd_owner_e last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last_q <= OWN_I;
    else if (take_grant)
      last_q <= grant_d ? OWN_D : OWN_I;
  end

  assign grant_d = d_rd_req && (!i_rd_req || last_q == OWN_I);
`else
  assign grant_d = d_rd_req;
`endif

  // Gate with reset so no grant can be seen while reset is held.
  assign take_grant = (state_q == ST_IDLE) && !reset && (i_rd_req || d_rd_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_I;
      type_q  <= 1'b0;
      addr_q  <= '0;
    end else if (take_grant) begin
      owner_q <= grant_d ? OWN_D : OWN_I;
      type_q  <= grant_d ? d_rd_type : i_rd_type;
      addr_q  <= grant_d ? d_rd_addr : i_rd_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (take_grant)        state_d = ST_AR;
      ST_AR:   if (arready)           state_d = ST_R;
      ST_R:    if (rvalid && rlast)   state_d = ST_DONE;
      ST_DONE:                        state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // AR fields are only driven while the address phase is live.
  always_comb begin
    i_rd_rdy    = take_grant && !grant_d;
    d_rd_rdy    = take_grant && grant_d;
    arvalid     = 1'b0;
    arid        = '0;
    araddr      = '0;
    arlen       = '0;
    arsize      = '0;
    arburst     = '0;
    rready      = 1'b0;
    i_ret_valid = 1'b0;
    d_ret_valid = 1'b0;
    unique case (state_q)
      ST_AR: begin
        arvalid = 1'b1;
        arid    = (owner_q == OWN_D) ? DCACHE_ID : ICACHE_ID;
        araddr  = type_q ? line_base(addr_q) : addr_q;
        arlen   = type_q ? ARLEN_LINE : ARLEN_WORD;
        arsize  = ARSIZE_WORD;
        arburst = ARBURST_INCR;
      end
      ST_R:    rready = 1'b1;
      ST_DONE: begin
        i_ret_valid = (owner_q == OWN_I);
        d_ret_valid = (owner_q == OWN_D);
      end
      default: ;
    endcase
  end

  cache_rd_beat_buffer u_beat_buffer (
    .clk   (clk),
    .reset (reset),
    .clear (take_grant),
    .wr_en ((state_q == ST_R) && rvalid),
    .wdata (rdata),
    .line  (line),
    .cnt   (beat_cnt)
  );

  assign ret_word   = type_q ? line : {224'b0, line[31:0]};
  assign i_ret_data = ret_word;
  assign d_ret_data = ret_word;

endmodule
